// File: rtl/rx_align_pkg.sv
// ============================================================================
// Module      : rx_align_pkg
// Description : Shared constants and state encoding for the RX word aligner.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rx_align_pkg;

    // K28.5 in both running disparities, bit0=a ... bit9=j
    localparam logic [9:0] c_COMMA_RDN = 10'h17C;
    localparam logic [9:0] c_COMMA_RDP = 10'h283;

    localparam int unsigned c_SLIP_MOD = 10;

    localparam logic [2:0] c_ST_HUNT   = 3'd0;
    localparam logic [2:0] c_ST_SLIP   = 3'd1;
    localparam logic [2:0] c_ST_WAIT   = 3'd2;
    localparam logic [2:0] c_ST_VERIFY = 3'd3;
    localparam logic [2:0] c_ST_LOCKED = 3'd4;

    typedef enum logic [2:0] {
        ST_HUNT   = c_ST_HUNT,
        ST_SLIP   = c_ST_SLIP,
        ST_WAIT   = c_ST_WAIT,
        ST_VERIFY = c_ST_VERIFY,
        ST_LOCKED = c_ST_LOCKED
    } align_state_e;

    function automatic logic [3:0] next_slip(input logic [3:0] cur);
        return (cur == 4'(c_SLIP_MOD - 1)) ? 4'd0 : cur + 4'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rx_comma_detect.sv
// ============================================================================
// Module      : rx_comma_detect
// Description : Combinational K28.5 comma match on a raw 10-bit word.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rx_comma_detect
    import rx_align_pkg::*;
(
    input  logic [9:0] rx_data,
    output logic       is_comma
);

    assign is_comma = (rx_data == c_COMMA_RDN) || (rx_data == c_COMMA_RDP);

endmodule

`default_nettype wire

// File: rtl/rx_word_align_ctrl.sv
// ============================================================================
// Module      : rx_word_align_ctrl
// Description : Comma-based word alignment controller driving deserializer
//               bitslip. Optional lock-loss statistics: RX_ALIGN_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rx_word_align_ctrl
    import rx_align_pkg::*;
#(
    parameter int unsigned LOCK_CNT   = 4,
    parameter int unsigned HUNT_LEN   = 16,
    parameter int unsigned SLIP_WAIT  = 4,
    parameter int unsigned ERR_THRESH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  rx_data,
    input  logic        rx_valid,
    input  logic        code_err,
    output logic        bitslip,
    output logic        aligned,
    output logic [9:0]  data_out,
    output logic        data_valid,
    output logic [3:0]  slip_cnt,
    output logic [15:0] lock_loss_cnt
);

    localparam int c_MISS_W = $clog2(HUNT_LEN + 1);
    localparam int c_GOOD_W = $clog2(LOCK_CNT + 1);
    localparam int c_ERR_W  = $clog2(ERR_THRESH + 1);
    localparam int c_WAIT_W = $clog2(SLIP_WAIT + 1);

    // Terminal values: a counter at *_LAST plus one more event hits the threshold
    localparam logic [c_MISS_W-1:0] c_MISS_LAST = c_MISS_W'(HUNT_LEN - 1);
    localparam logic [c_GOOD_W-1:0] c_GOOD_LAST = c_GOOD_W'(LOCK_CNT - 1);
    localparam logic [c_ERR_W-1:0]  c_ERR_LAST  = c_ERR_W'(ERR_THRESH - 1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(SLIP_WAIT - 1);

    align_state_e        r_state_q,   w_state_d;
    logic [c_MISS_W-1:0] r_miss_q,    w_miss_d;
    logic [c_GOOD_W-1:0] r_good_q,    w_good_d;
    logic [c_ERR_W-1:0]  r_err_q,     w_err_d;
    logic [c_WAIT_W-1:0] r_wait_q,    w_wait_d;
    logic [3:0]          r_slip_q,    w_slip_d;
    logic                r_bitslip_q, w_bitslip_d;
    logic                r_aligned_q, w_aligned_d;
    logic [9:0]          r_data_q,    w_data_d;
    logic                r_dv_q,      w_dv_d;

    logic w_is_comma;

    rx_comma_detect u_comma_detect (
        .rx_data  (rx_data),
        .is_comma (w_is_comma)
    );

    always_comb begin
        w_state_d = r_state_q;
        w_miss_d  = r_miss_q;
        w_good_d  = r_good_q;
        w_err_d   = r_err_q;
        w_wait_d  = r_wait_q;
        w_slip_d  = r_slip_q;
        w_data_d  = rx_data;
        w_dv_d    = rx_valid & r_aligned_q;

        case (r_state_q)
            ST_HUNT: begin
                if (rx_valid) begin
                    if (w_is_comma) begin
                        w_good_d  = c_GOOD_W'(1);
                        w_err_d   = '0;
                        w_state_d = (LOCK_CNT <= 1) ? ST_LOCKED : ST_VERIFY;
                    end else if (r_miss_q == c_MISS_LAST) begin
                        w_miss_d  = '0;
                        w_slip_d  = next_slip(r_slip_q);
                        w_state_d = ST_SLIP;
                    end else begin
                        w_miss_d  = r_miss_q + c_MISS_W'(1);
                    end
                end
            end

            ST_SLIP: begin
                w_wait_d  = '0;
                w_state_d = ST_WAIT;
            end

            ST_WAIT: begin
                if (r_wait_q == c_WAIT_LAST) begin
                    w_miss_d  = '0;
                    w_state_d = ST_HUNT;
                end else begin
                    w_wait_d  = r_wait_q + c_WAIT_W'(1);
                end
            end

            ST_VERIFY: begin
                // A code error disqualifies the word even if it matches a comma
                if (rx_valid) begin
                    if (code_err) begin
                        w_slip_d  = next_slip(r_slip_q);
                        w_state_d = ST_SLIP;
                    end else if (w_is_comma) begin
                        if (r_good_q == c_GOOD_LAST) begin
                            w_err_d   = '0;
                            w_state_d = ST_LOCKED;
                        end else begin
                            w_good_d  = r_good_q + c_GOOD_W'(1);
                        end
                    end
                end
            end

            ST_LOCKED: begin
                if (rx_valid) begin
                    if (code_err) begin
                        if (r_err_q == c_ERR_LAST) begin
                            w_err_d   = '0;
                            w_miss_d  = '0;
                            w_state_d = ST_HUNT;
                        end else begin
                            w_err_d   = r_err_q + c_ERR_W'(1);
                        end
                    end else if (w_is_comma) begin
                        w_err_d = '0;
                    end
                end
            end

            default: begin
                w_state_d = ST_HUNT;
            end
        endcase

        w_bitslip_d = (w_state_d == ST_SLIP);
        w_aligned_d = (w_state_d == ST_LOCKED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q   <= ST_HUNT;
            r_miss_q    <= '0;
            r_good_q    <= '0;
            r_err_q     <= '0;
            r_wait_q    <= '0;
            r_slip_q    <= '0;
            r_bitslip_q <= 1'b0;
            r_aligned_q <= 1'b0;
            r_data_q    <= '0;
            r_dv_q      <= 1'b0;
        end else begin
            r_state_q   <= w_state_d;
            r_miss_q    <= w_miss_d;
            r_good_q    <= w_good_d;
            r_err_q     <= w_err_d;
            r_wait_q    <= w_wait_d;
            r_slip_q    <= w_slip_d;
            r_bitslip_q <= w_bitslip_d;
            r_aligned_q <= w_aligned_d;
            r_data_q    <= w_data_d;
            r_dv_q      <= w_dv_d;
        end
    end

    assign bitslip    = r_bitslip_q;
    assign aligned    = r_aligned_q;
    assign data_out   = r_data_q;
    assign data_valid = r_dv_q;
    assign slip_cnt   = r_slip_q;

`ifdef RX_ALIGN_STATS_EN
    logic        w_lost;
    logic [15:0] r_loss_q, w_loss_d;

    assign w_lost = (r_state_q == ST_LOCKED) && (w_state_d == ST_HUNT);

    always_comb begin
        w_loss_d = r_loss_q;
        if (w_lost && (r_loss_q != 16'hFFFF)) begin
            w_loss_d = r_loss_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_loss_q <= '0;
        end else begin
            r_loss_q <= w_loss_d;
        end
    end

    assign lock_loss_cnt = r_loss_q;
`else
    assign lock_loss_cnt = 16'h0000;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rx_word_align_ctrl.sv
// ============================================================================
// Module      : tb_rx_word_align_ctrl
// Description : Self-checking bench for rx_word_align_ctrl (reference model +
//               directed scenarios + randomized traffic).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_rx_word_align_ctrl;

    localparam int LOCK_CNT   = 4;
    localparam int HUNT_LEN   = 16;
    localparam int SLIP_WAIT  = 4;
    localparam int ERR_THRESH = 8;

    logic        clk      = 1'b0;
    logic        rst      = 1'b1;
    logic [9:0]  rx_data  = '0;
    logic        rx_valid = 1'b0;
    logic        code_err = 1'b0;
    logic        bitslip;
    logic        aligned;
    logic [9:0]  data_out;
    logic        data_valid;
    logic [3:0]  slip_cnt;
    logic [15:0] lock_loss_cnt;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    rx_word_align_ctrl #(
        .LOCK_CNT   (LOCK_CNT),
        .HUNT_LEN   (HUNT_LEN),
        .SLIP_WAIT  (SLIP_WAIT),
        .ERR_THRESH (ERR_THRESH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .code_err      (code_err),
        .bitslip       (bitslip),
        .aligned       (aligned),
        .data_out      (data_out),
        .data_valid    (data_valid),
        .slip_cnt      (slip_cnt),
        .lock_loss_cnt (lock_loss_cnt)
    );

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chkb(input string nm, input logic act, input logic exp);
        chk(nm, {15'b0, act}, {15'b0, exp});
    endtask

    function automatic bit is_k285(input logic [9:0] w);
        return (w == 10'h17C) || (w == 10'h283);
    endfunction

    // Reference model: alignment phase plus the counters the rules talk about
    typedef enum int {M_SEARCH, M_SLIPPING, M_SETTLE, M_CONFIRM, M_LOCK} mode_t;
    mode_t      m_mode  = M_SEARCH;
    int         m_miss  = 0;
    int         m_good  = 0;
    int         m_errs  = 0;
    int         m_timer = 0;
    int         m_slip  = 0;
    int         m_loss  = 0;
    logic [9:0] m_data  = '0;
    logic       m_dv    = 1'b0;
    bit         m_live  = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_mode <= M_SEARCH; m_miss <= 0; m_good <= 0; m_errs <= 0;
            m_timer <= 0; m_slip <= 0; m_loss <= 0; m_data <= '0; m_dv <= 1'b0;
            m_live <= 1'b1;
        end else begin
            m_data <= rx_data;
            m_dv   <= rx_valid && (m_mode == M_LOCK);
            case (m_mode)
                M_SEARCH: if (rx_valid) begin
                    if (is_k285(rx_data)) begin
                        m_good <= 1; m_mode <= M_CONFIRM;
                    end else if (m_miss + 1 >= HUNT_LEN) begin
                        m_mode <= M_SLIPPING; m_slip <= (m_slip + 1) % 10; m_miss <= 0;
                    end else begin
                        m_miss <= m_miss + 1;
                    end
                end
                M_SLIPPING: begin
                    m_mode <= M_SETTLE; m_timer <= 1;
                end
                M_SETTLE: begin
                    if (m_timer >= SLIP_WAIT) begin
                        m_mode <= M_SEARCH; m_miss <= 0;
                    end else begin
                        m_timer <= m_timer + 1;
                    end
                end
                M_CONFIRM: if (rx_valid) begin
                    if (code_err) begin
                        m_mode <= M_SLIPPING; m_slip <= (m_slip + 1) % 10;
                    end else if (is_k285(rx_data)) begin
                        if (m_good + 1 >= LOCK_CNT) begin
                            m_mode <= M_LOCK; m_errs <= 0;
                        end else begin
                            m_good <= m_good + 1;
                        end
                    end
                end
                M_LOCK: if (rx_valid) begin
                    if (code_err) begin
                        if (m_errs + 1 >= ERR_THRESH) begin
                            m_mode <= M_SEARCH; m_miss <= 0; m_errs <= 0;
`ifdef RX_ALIGN_STATS_EN
                            if (m_loss < 65535) m_loss <= m_loss + 1;
`endif
                        end else begin
                            m_errs <= m_errs + 1;
                        end
                    end else if (is_k285(rx_data)) begin
                        m_errs <= 0;
                    end
                end
                default: m_mode <= M_SEARCH;
            endcase
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chkb("cyc_bitslip", bitslip, m_mode == M_SLIPPING);
            chkb("cyc_aligned", aligned, m_mode == M_LOCK);
            chk("cyc_data_out", {6'b0, data_out}, {6'b0, m_data});
            chkb("cyc_data_valid", data_valid, m_dv);
            chk("cyc_slip_cnt", {12'b0, slip_cnt}, 16'(m_slip));
            chk("cyc_lock_loss", lock_loss_cnt, 16'(m_loss));
        end
    end

    logic       disp      = 1'b0;
    logic [9:0] last_word = '0;

    task automatic step(input logic [9:0] d, input logic v, input logic e, input logic r);
        @(negedge clk);
        rx_data = d; rx_valid = v; code_err = e; rst = r;
        last_word = d;
        @(posedge clk);
        #1;
    endtask

    task automatic commas(input int n);
        for (int k = 0; k < n; k++) begin
            step(disp ? 10'h283 : 10'h17C, 1'b1, 1'b0, 1'b0);
            disp = ~disp;
        end
    endtask

    task automatic junk(input int n);
        for (int k = 0; k < n; k++) step(10'h0AA, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(10'h17C, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic errs(input int n);
        for (int k = 0; k < n; k++) step(10'h155, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        step(10'h000, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic chk_all_zero(input string nm);
        chkb({nm, "_aligned"}, aligned, 1'b0);
        chkb({nm, "_bitslip"}, bitslip, 1'b0);
        chk({nm, "_data_out"}, {6'b0, data_out}, 16'h0);
        chkb({nm, "_data_valid"}, data_valid, 1'b0);
        chk({nm, "_slip_cnt"}, {12'b0, slip_cnt}, 16'h0);
        chk({nm, "_lock_loss"}, lock_loss_cnt, 16'h0);
    endtask

    int         rnd_err_pct;
    logic [9:0] rnd_d;

    initial begin
        // Reset state, then lock on continuous comma alternation
        do_reset(); do_reset();
        chk_all_zero("rst");
        commas(3);
        chkb("s1_pre_lock", aligned, 1'b0);
        commas(1);
        chkb("s1_lock", aligned, 1'b1);
        chkb("s1_dv_lag", data_valid, 1'b0);
        commas(1);
        chkb("s1_dv", data_valid, 1'b1);
        chk("s1_dout", {6'b0, data_out}, {6'b0, last_word});
        chk("s1_slip", {12'b0, slip_cnt}, 16'h0);

        // Failed hunt: slip pulse, ignored settle window, then lock
        do_reset();
        junk(15);
        chkb("s2_no_slip_yet", bitslip, 1'b0);
        junk(1);
        chkb("s2_slip_pulse", bitslip, 1'b1);
        chk("s2_slip_cnt", {12'b0, slip_cnt}, 16'h1);
        commas(1);
        chkb("s2_pulse_end", bitslip, 1'b0);
        commas(4);
        commas(3);
        chkb("s2_not_locked", aligned, 1'b0);
        commas(1);
        chkb("s2_locked", aligned, 1'b1);

        // Ten failed hunts walk slip_cnt through 1..9 and back to 0
        do_reset();
        for (int i = 0; i < 10; i++) begin
            junk(16);
            chk("s3_slip_seq", {12'b0, slip_cnt}, 16'((i + 1) % 10));
            idle(5);
        end

        // Code error on a comma during verify forces a slip; verify restarts at 1
        do_reset();
        commas(2);
        step(10'h17C, 1'b1, 1'b1, 1'b0);
        chkb("s4_err_slip", bitslip, 1'b1);
        chk("s4_slip_cnt", {12'b0, slip_cnt}, 16'h1);
        idle(5);
        commas(1);
        chkb("s4_restart", aligned, 1'b0);
        commas(2);
        chkb("s4_good3", aligned, 1'b0);
        commas(1);
        chkb("s4_relock", aligned, 1'b1);

        // Error budget while locked; comma clears it, 8 in a row loses lock
        errs(7);
        chkb("s5_7err", aligned, 1'b1);
        commas(1);
        errs(7);
        chkb("s5_7err_again", aligned, 1'b1);
        errs(1);
        chkb("s5_lost", aligned, 1'b0);
        chk("s5_slip_kept", {12'b0, slip_cnt}, 16'h1);
`ifdef RX_ALIGN_STATS_EN
        chk("s5_loss_cnt", lock_loss_cnt, 16'h1);
`else
        chk("s5_loss_cnt", lock_loss_cnt, 16'h0);
`endif

        // Reset mid-settle and mid-lock
        do_reset();
        junk(16);
        idle(2);
        do_reset();
        chk_all_zero("s6_wait_rst");
        commas(4);
        chkb("s6_lock", aligned, 1'b1);
        do_reset();
        chk_all_zero("s6_lock_rst");
        commas(4);
        chkb("s6_relock", aligned, 1'b1);

        // Randomized traffic in phases of increasing error rate
        for (int i = 0; i < 4000; i++) begin
            rnd_err_pct = (i / 1000) * 12;
            if ($urandom_range(0, 99) < 45)
                rnd_d = ($urandom_range(0, 1) == 1) ? 10'h17C : 10'h283;
            else
                rnd_d = 10'($urandom);
            step(rnd_d,
                 $urandom_range(0, 9) < 8,
                 $urandom_range(0, 99) < rnd_err_pct,
                 $urandom_range(0, 599) == 0);
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule

`default_nettype wire
